fmap_rd_addr_gen: RTL and testbench
===================================

// Module: fmap_rd_addr_gen
// PURPOSE
//  Parametrised read-address generator for pooling/conv feature-map memories.
//  Sweeps a MAP_W x MAP_H map once per channel for CHANNELS channels.
//  Emits the address stream under a valid/ready handshake so a stalled consumer can apply backpressure.
//  Inserts programmable idle gaps: INIT_DELAY cycles before the first channel, CH_GAP cycles between channels.
//  Sits between a layer's output RAM and the next layer's input stage (e.g. P2 -> FC).
// PARAMETERS
//  MAP_W      4   map width in pixels (>=1)
//  MAP_H      4   map height in pixels (>=1)
//  CHANNELS   12  number of channel passes (>=1)
//  INIT_DELAY 15  idle cycles after start before first address (0 allowed)
//  CH_GAP     0   idle cycles between channels (0 = back-to-back)
//  PIX_W      derived: max(1,$clog2(MAP_W*MAP_H)).
//  CH_W       derived: max(1,$clog2(CHANNELS)).
// PORTS
//  clk         in   1      rising-edge clock
//  reset_n     in   1      asynchronous, active-low reset
//  start       in   1      1-cycle pulse; launches a sweep from IDLE or DONE
//  enable      in   1      0 freezes all counters/state and forces addr_valid=0
//  addr_valid  out  1      pix_addr/chan are valid this cycle
//  addr_ready  in   1      consumer accepts the current address
//  pix_addr    out  PIX_W  pixel address within the map, 0..MAP_W*MAP_H-1
//  chan        out  CH_W   current channel, 0..CHANNELS-1
//  last        out  1      high with addr_valid on the final address (chan=CHANNELS-1, pix=max)
//  busy        out  1      state is WAIT or RUN
//  done        out  1      high in DONE; held until next accepted start or reset
// BEHAVIOUR
//  Reset (async, any state): state=IDLE; pix_addr, chan, delay counter = 0; all outputs 0.
//  Output values:
//   - addr_valid = (state==RUN) && enable.
//   - pix_addr/chan are registered and driven directly from the counters.
//  IDLE: start&&enable -> WAIT with dly=INIT_DELAY. If INIT_DELAY==0, go directly to RUN.
//  WAIT: while enable, dly decrements; dly==0 and enable -> RUN on the next edge.
//   - Reaching RUN with delay D: first addr_valid appears D+1 cycles after start.
//   - With D=0: first addr_valid appears 1 cycle after start.
//  RUN: transfer = addr_valid && addr_ready. Counters change only on a transfer.
//   - pix wraps MAP_W*MAP_H-1 -> 0, chan increments.
//   - If CH_GAP>0, go to WAIT with dly=CH_GAP, otherwise stay in RUN.
//   - Transfer with last=1 -> DONE. pix and chan wrap to 0.
//   - No transfer: pix_addr/chan are held stable. They must not change while valid&&!ready.
//  DONE: done=1, busy=0. start&&enable -> WAIT (clears done, counters already 0).
//  start while busy: ignored, no restart.
//  enable=0 (any state): state, counters and dly are frozen. addr_valid=0.
//   - Address outputs hold their values. start is ignored.
//   - On re-enable, resume exactly where frozen.
//  Degenerate size MAP_W*MAP_H=1: pix_addr stays 0. Every transfer advances chan.
//  CHANNELS=1: last asserts on pix = MAP_W*MAP_H-1 of channel 0.
//  Width rule: counters are compared against full-width constants. No reliance on natural 2^N wrap.
// CONFIGURATION
//  FMAP_RD_ROWCOL_EN defined:
//   - Adds outputs row [$clog2(MAP_H) max 1] and col [$clog2(MAP_W) max 1].
//   - row/col track pix_addr with pix_addr = row*MAP_W + col, and are maintained as separate counters.
//   - col wraps at MAP_W-1 and increments row; both reset/wrap to 0 alongside pix_addr.
//  FMAP_RD_ROWCOL_EN undefined: row/col ports and counters are absent; all other behaviour is identical.
// TESTING
//  Defaults, ready=1, start@t0 -> first valid at t0+16 (pix0,ch0).
//   - 192 consecutive transfers follow; last=1 on ch11 pix15, then done=1 at the next edge.
//  ready toggling 1/0 pseudo-random -> every (chan,pix) pair is seen exactly once, in order.
//   - Outputs stay stable across every valid&&!ready cycle.
//  CH_GAP=3, MAP 2x2, CHANNELS=2 -> ch0 pix0..3 with no gaps, then 3 cycles with valid=0.
//   - ch1 pix0..3 follows; done asserts after 8 transfers.
//  enable=0 for 5 cycles mid-WAIT and mid-RUN -> valid=0 and state frozen.
//   - Sequence resumes with no skipped or repeated address; total latency grows by exactly 10 cycles.
//  reset_n low mid-RUN at ch5 pix7 -> outputs 0 immediately (asynchronously).
//   - New start after release begins at ch0 pix0 with the full INIT_DELAY.
//  start pulsed during RUN -> ignored; start in DONE -> done=0, new sweep begins.
//   - With FMAP_RD_ROWCOL_EN: row/col equal pix_addr/MAP_W and pix_addr%MAP_W on every transfer.

Source files
------------

// File: rtl/fmap_rd_addr_gen.sv
// -----------------------------------------------------------------------------
// fmap_rd_addr_gen
//
// Read-address generator for a feature-map RAM sitting between one layer's
// output memory and the next layer's input stage. It sweeps a MAP_W x MAP_H map
// once per channel, for CHANNELS channels. Addresses are offered under a
// valid/ready handshake, so a stalled consumer can hold the stream.
//
// Idle gaps are programmable:
//   - INIT_DELAY idle cycles after start, before the first address.
//   - CH_GAP idle cycles between channels.
// With delay D, the first addr_valid appears D+1 cycles after the start pulse.
//
// Ports
//   clk         rising-edge clock
//   reset_n     asynchronous active-low reset
//   start       1-cycle pulse; launches a sweep from IDLE or DONE
//   enable      0 freezes state/counters and forces addr_valid low
//   addr_valid  pix_addr/chan carry a valid address this cycle
//   addr_ready  consumer accepts the current address
//   pix_addr    pixel index within the map, 0..MAP_W*MAP_H-1
//   chan        channel index, 0..CHANNELS-1
//   last        with addr_valid on the final address of the sweep
//   busy        sweep in progress (WAIT or RUN)
//   done        sweep finished; held until the next accepted start or reset
//   row, col    (FMAP_RD_ROWCOL_EN only) pix_addr split into map coordinates,
//               kept as separate counters
//
// Configuration macro: FMAP_RD_ROWCOL_EN adds the row/col outputs and counters.
// -----------------------------------------------------------------------------
module fmap_rd_addr_gen #(
  parameter int MAP_W      = 4,
  parameter int MAP_H      = 4,
  parameter int CHANNELS   = 12,
  parameter int INIT_DELAY = 15,
  parameter int CH_GAP     = 0,
  localparam int PIX_W     = (MAP_W * MAP_H > 1) ? $clog2(MAP_W * MAP_H) : 1,
  localparam int CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
`ifdef FMAP_RD_ROWCOL_EN
  ,
  localparam int ROW_W     = (MAP_H > 1) ? $clog2(MAP_H) : 1,
  localparam int COL_W     = (MAP_W > 1) ? $clog2(MAP_W) : 1
`endif
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             enable,
  output logic             addr_valid,
  input  logic             addr_ready,
  output logic [PIX_W-1:0] pix_addr,
  output logic [CH_W-1:0]  chan,
  output logic             last,
  output logic             busy,
  output logic             done
`ifdef FMAP_RD_ROWCOL_EN
  ,
  output logic [ROW_W-1:0] row,
  output logic [COL_W-1:0] col
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RUN,
    S_DONE
  } state_t;

  localparam int NPIX = MAP_W * MAP_H;

  // Terminal values held at full counter width so wrap detection never depends
  // on a counter overflowing naturally at 2^N.
  localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(NPIX - 1);
  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(CHANNELS - 1);

  // The delay counter is loaded with (gap - 1) and the RUN transition happens
  // on the cycle it reads zero, so WAIT lasts exactly `gap` cycles.
  localparam int DLY_MAX = (INIT_DELAY > CH_GAP) ? INIT_DELAY : CH_GAP;
  localparam int DLY_W   = (DLY_MAX > 1) ? $clog2(DLY_MAX) : 1;
  localparam logic [DLY_W-1:0] INIT_LOAD = DLY_W'((INIT_DELAY > 0) ? INIT_DELAY - 1 : 0);
  localparam logic [DLY_W-1:0] GAP_LOAD  = DLY_W'((CH_GAP > 0) ? CH_GAP - 1 : 0);

`ifdef FMAP_RD_ROWCOL_EN
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(MAP_W - 1);
`endif

  state_t            state_q, state_d;
  logic [PIX_W-1:0]  pix_q,   pix_d;
  logic [CH_W-1:0]   chan_q,  chan_d;
  logic [DLY_W-1:0]  dly_q,   dly_d;
`ifdef FMAP_RD_ROWCOL_EN
  logic [ROW_W-1:0]  row_q,   row_d;
  logic [COL_W-1:0]  col_q,   col_d;
`endif

  // ---------------------------------------------------------------------------
  // State and counter registers
  // ---------------------------------------------------------------------------
  // NOTE: every flop is written with <= so all registers update together from
  // values computed in the previous cycle, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      pix_q   <= '0;
      chan_q  <= '0;
      dly_q   <= '0;
`ifdef FMAP_RD_ROWCOL_EN
      row_q   <= '0;
      col_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      pix_q   <= pix_d;
      chan_q  <= chan_d;
      dly_q   <= dly_d;
`ifdef FMAP_RD_ROWCOL_EN
      row_q   <= row_d;
      col_q   <= col_d;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and counter logic
  // ---------------------------------------------------------------------------
  // NOTE: each _d signal takes its hold value before any branch, so paths that
  // do not assign it keep the register value instead of inferring a latch.
  always_comb begin
    state_d = state_q;
    pix_d   = pix_q;
    chan_d  = chan_q;
    dly_d   = dly_q;
`ifdef FMAP_RD_ROWCOL_EN
    row_d   = row_q;
    col_d   = col_q;
`endif

    // With enable low nothing moves; the sweep resumes exactly where it stopped.
    if (enable) begin
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            pix_d  = '0;
            chan_d = '0;
`ifdef FMAP_RD_ROWCOL_EN
            row_d  = '0;
            col_d  = '0;
`endif
            if (INIT_DELAY == 0) begin
              state_d = S_RUN;
            end else begin
              state_d = S_WAIT;
              dly_d   = INIT_LOAD;
            end
          end
        end

        S_WAIT: begin
          if (dly_q == '0) begin
            state_d = S_RUN;
          end else begin
            dly_d = dly_q - DLY_W'(1);
          end
        end

        S_RUN: begin
          // addr_valid is high here (RUN and enabled), so ready alone marks a
          // transfer. Without one, all counters hold.
          if (addr_ready) begin
            if (pix_q == PIX_LAST) begin
              pix_d = '0;
`ifdef FMAP_RD_ROWCOL_EN
              row_d = '0;
              col_d = '0;
`endif
              if (chan_q == CH_LAST) begin
                chan_d  = '0;
                state_d = S_DONE;
              end else begin
                chan_d = chan_q + CH_W'(1);
                if (CH_GAP > 0) begin
                  state_d = S_WAIT;
                  dly_d   = GAP_LOAD;
                end
              end
            end else begin
              pix_d = pix_q + PIX_W'(1);
`ifdef FMAP_RD_ROWCOL_EN
              if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = row_q + ROW_W'(1);
              end else begin
                col_d = col_q + COL_W'(1);
              end
`endif
            end
          end
        end

        default: state_d = S_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    addr_valid = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    last       = 1'b0;

    unique case (state_q)
      S_WAIT:  busy = 1'b1;
      S_RUN: begin
        busy       = 1'b1;
        addr_valid = enable;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase

    last     = addr_valid && (pix_q == PIX_LAST) && (chan_q == CH_LAST);
    pix_addr = pix_q;
    chan     = chan_q;
`ifdef FMAP_RD_ROWCOL_EN
    row      = row_q;
    col      = col_q;
`endif
  end

endmodule

// File: tb/tb_fmap_rd_addr_gen.sv
// -----------------------------------------------------------------------------
// tb_fmap_rd_addr_gen
//
// Two instances:
//   u_dut - default geometry (4x4 map, 12 channels, INIT_DELAY 15, no channel gap).
//           Its address stream is checked by a scoreboard.
//   u_gap - 2x2 map, 2 channels, INIT_DELAY 2, CH_GAP 3.
//           Checked cycle by cycle against an arithmetic timing model.
//
// Expected addresses come from plain nested loops over channel and pixel.
// Inputs are driven 1 ns after the rising edge; outputs are sampled on the
// falling edge.
// -----------------------------------------------------------------------------
module tb_fmap_rd_addr_gen;

  localparam int MAP_W      = 4;
  localparam int MAP_H      = 4;
  localparam int CHANNELS   = 12;
  localparam int INIT_DELAY = 15;
  localparam int CH_GAP     = 0;
  localparam int NPIX       = MAP_W * MAP_H;
  localparam int TOTAL      = NPIX * CHANNELS;
  localparam int PIX_W      = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
`ifdef FMAP_RD_ROWCOL_EN
  localparam int ROW_W      = (MAP_H > 1) ? $clog2(MAP_H) : 1;
  localparam int COL_W      = (MAP_W > 1) ? $clog2(MAP_W) : 1;
`endif

  localparam int G_W        = 2;
  localparam int G_H        = 2;
  localparam int G_CH       = 2;
  localparam int G_INIT     = 2;
  localparam int G_GAP      = 3;
  localparam int G_NPIX     = G_W * G_H;
  localparam int G_LAST_OFF = G_INIT + 1 + (G_CH - 1) * (G_NPIX + G_GAP) + G_NPIX - 1;

  typedef struct {
    int chan;
    int pix;
    bit last;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             start;
  logic             enable;
  logic             addr_ready;
  logic             addr_valid;
  logic [PIX_W-1:0] pix_addr;
  logic [CH_W-1:0]  chan;
  logic             last;
  logic             busy;
  logic             done;
`ifdef FMAP_RD_ROWCOL_EN
  logic [ROW_W-1:0] row;
  logic [COL_W-1:0] col;
  logic             g_row;
  logic             g_col;
`endif

  logic       g_start;
  logic       g_enable;
  logic       g_ready;
  logic       g_valid;
  logic [1:0] g_pix;
  logic [0:0] g_chan;
  logic       g_last;
  logic       g_busy;
  logic       g_done;

  int   cyc = 0;
  int   ready_mode = 0;
  int   start_cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  exp_t sb_q[$];

  fmap_rd_addr_gen #(
    .MAP_W(MAP_W), .MAP_H(MAP_H), .CHANNELS(CHANNELS),
    .INIT_DELAY(INIT_DELAY), .CH_GAP(CH_GAP)
  ) u_dut (
    .clk(clk), .reset_n(reset_n), .start(start), .enable(enable),
    .addr_valid(addr_valid), .addr_ready(addr_ready),
    .pix_addr(pix_addr), .chan(chan), .last(last), .busy(busy), .done(done)
`ifdef FMAP_RD_ROWCOL_EN
    , .row(row), .col(col)
`endif
  );

  fmap_rd_addr_gen #(
    .MAP_W(G_W), .MAP_H(G_H), .CHANNELS(G_CH),
    .INIT_DELAY(G_INIT), .CH_GAP(G_GAP)
  ) u_gap (
    .clk(clk), .reset_n(reset_n), .start(g_start), .enable(g_enable),
    .addr_valid(g_valid), .addr_ready(g_ready),
    .pix_addr(g_pix), .chan(g_chan), .last(g_last), .busy(g_busy), .done(g_done)
`ifdef FMAP_RD_ROWCOL_EN
    , .row(g_row), .col(g_col)
`endif
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Consumer: always ready, or a coin flip per cycle.
  initial begin
    addr_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      addr_ready = (ready_mode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference model: one full sweep in channel-major order.
  task automatic push_sweep();
    for (int c = 0; c < CHANNELS; c++) begin
      for (int p = 0; p < NPIX; p++) begin
        exp_t e;
        e.chan = c;
        e.pix  = p;
        e.last = (c == CHANNELS - 1) && (p == NPIX - 1);
        sb_q.push_back(e);
      end
    end
  endtask

  // Monitor: pops one expectation per transfer. It also checks that addresses
  // hold across a stall and that last stays low whenever valid is low.
  initial begin : monitor
    bit hold_vld;
    int hold_pix;
    int hold_chan;
    exp_t e;
    hold_vld = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        hold_vld = 1'b0;
      end else begin
        if (hold_vld) begin
          check("hold_pix", pix_addr, hold_pix);
          check("hold_chan", chan, hold_chan);
        end
        if (addr_valid && addr_ready) begin
          if (sb_q.size() == 0) begin
            check("unexpected_xfer", 1, 0);
          end else begin
            e = sb_q.pop_front();
            check("xfer_chan", chan, e.chan);
            check("xfer_pix", pix_addr, e.pix);
            check("xfer_last", last, e.last);
`ifdef FMAP_RD_ROWCOL_EN
            check("xfer_row", row, e.pix / MAP_W);
            check("xfer_col", col, e.pix % MAP_W);
`endif
          end
        end
        if (!addr_valid) check("last_idle", last, 0);
        hold_vld  = addr_valid && !addr_ready;
        hold_pix  = int'(pix_addr);
        hold_chan = int'(chan);
      end
    end
  end

  task automatic issue_start();
    @(posedge clk);
    #1;
    start     = 1'b1;
    start_cyc = cyc;
    push_sweep();
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // A start the DUT is expected to ignore, so no expectations are pushed.
  task automatic pulse_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_valid(input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (addr_valid) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) check("valid_timeout", 0, 1);
  endtask

  task automatic wait_done(input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) check("done_timeout", 0, 1);
  endtask

  task automatic freeze(input int n);
    @(posedge clk);
    #1 enable = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("frozen_valid", addr_valid, 0);
      check("frozen_busy", busy, 1);
      @(posedge clk);
    end
    #1 enable = 1'b1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid"}, addr_valid, 0);
    check({tag, "_pix"}, pix_addr, 0);
    check({tag, "_chan"}, chan, 0);
    check({tag, "_last"}, last, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
`ifdef FMAP_RD_ROWCOL_EN
    check({tag, "_row"}, row, 0);
    check({tag, "_col"}, col, 0);
`endif
  endtask

  initial begin
    int at;
    int found;
    int g_s;
    int g_xfers;
    reset_n  = 1'b0;
    start    = 1'b0;
    enable   = 1'b1;
    g_start  = 1'b0;
    g_enable = 1'b1;
    g_ready  = 1'b1;

    // Reset state.
    #2;
    check_zero("reset");
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    // A: always ready; check first-address latency, then done latency.
    issue_start();
    wait_valid(100, at);
    check("a_first_valid_lat", at - start_cyc, INIT_DELAY + 1);
    wait_done(TOTAL + 100, at);
    check("a_done_lat", at - start_cyc, INIT_DELAY + 1 + TOTAL);
    check("a_busy_in_done", busy, 0);
    check("a_sb_empty", sb_q.size(), 0);
    repeat (3) @(negedge clk);
    check("a_done_held", done, 1);

    // B: restart from DONE with random backpressure; starts issued in WAIT and
    // in RUN must be ignored.
    ready_mode = 1;
    issue_start();
    @(negedge clk);
    check("b_done_cleared", done, 0);
    check("b_busy", busy, 1);
    repeat (3) @(posedge clk);
    pulse_start();
    wait_valid(100, at);
    repeat (30) @(posedge clk);
    pulse_start();
    wait_done(8 * TOTAL, at);
    check("b_sb_empty", sb_q.size(), 0);
    ready_mode = 0;

    // A start with enable low is ignored in DONE.
    @(posedge clk);
    #1 enable = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    enable = 1'b1;
    repeat (2) @(negedge clk);
    check("en0_start_done", done, 1);
    check("en0_start_busy", busy, 0);

    // C: two 5-cycle freezes, one in WAIT and one in RUN, add exactly 10 cycles.
    issue_start();
    repeat (4) @(posedge clk);
    freeze(5);
    wait_valid(100, at);
    check("c_first_valid_lat", at - start_cyc, INIT_DELAY + 1 + 5);
    repeat (50) @(posedge clk);
    freeze(5);
    wait_done(TOTAL + 100, at);
    check("c_done_lat", at - start_cyc, INIT_DELAY + 1 + TOTAL + 10);
    check("c_sb_empty", sb_q.size(), 0);

    // D: asynchronous reset mid-RUN at ch5 pix7, then a clean restart.
    issue_start();
    found = 0;
    for (int i = 0; i < 4 * TOTAL && found == 0; i++) begin
      @(negedge clk);
      if (addr_valid && chan == 5 && pix_addr == 7) found = 1;
    end
    check("d_reach_ch5_pix7", found, 1);
    #2 reset_n = 1'b0;
    #1;
    check_zero("d_async_reset");
    sb_q.delete();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    check_zero("d_after_release");
    issue_start();
    wait_valid(100, at);
    check("d_first_valid_lat", at - start_cyc, INIT_DELAY + 1);
    wait_done(TOTAL + 100, at);
    check("d_done_lat", at - start_cyc, INIT_DELAY + 1 + TOTAL);
    check("d_sb_empty", sb_q.size(), 0);

    // E: channel gap instance, checked cycle by cycle against the timing model.
    @(posedge clk);
    #1 g_start = 1'b1;
    g_s = cyc;
    @(posedge clk);
    #1 g_start = 1'b0;
    g_xfers = 0;
    for (int off = 1; off <= G_LAST_OFF + 2; off++) begin
      int t;
      int ev;
      int ep;
      int ec;
      @(negedge clk);
      t  = (cyc - g_s) - (G_INIT + 1);
      ev = 0;
      ep = 0;
      ec = 0;
      if (t >= 0 && (t / (G_NPIX + G_GAP)) < G_CH && (t % (G_NPIX + G_GAP)) < G_NPIX) begin
        ev = 1;
        ep = t % (G_NPIX + G_GAP);
        ec = t / (G_NPIX + G_GAP);
      end
      check("gap_valid", g_valid, ev);
      if (ev != 0) begin
        check("gap_pix", g_pix, ep);
        check("gap_chan", g_chan, ec);
      end
      if (g_valid) g_xfers++;
      check("gap_last", g_last, (cyc - g_s) == G_LAST_OFF);
      check("gap_done", g_done, (cyc - g_s) > G_LAST_OFF);
    end
    check("gap_xfers", g_xfers, G_CH * G_NPIX);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
